// File: rtl/led_pkg.sv
// Shared types and sizing helpers for the LED PWM controller.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_SOLID   = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared timing for all LED channels: prescaler, PWM frame counter,
// blink phase and the breathing triangle level.
module pwm_timebase
    import led_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                clk,
    input  logic                srst,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                frame_end,
    output logic                blink_phase,
    output logic [PWM_BITS-1:0] breath_level
);
    localparam int PRE_W = ch_width(PRESCALE);
    localparam int BLK_W = ch_width(BLINK_FRAMES);
    localparam logic [PRE_W-1:0]    PRE_MAX    = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0]    BLK_MAX    = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
    localparam logic [PWM_BITS-1:0] BREATH_TOP = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] BREATH_BOT = PWM_BITS'(1);

    logic [PRE_W-1:0]    presc_reg, presc_next;
    logic [PWM_BITS-1:0] pwm_cnt_reg, pwm_cnt_next;
    logic [BLK_W-1:0]    blink_cnt_reg, blink_cnt_next;
    logic                blink_phase_reg, blink_phase_next;
    logic [PWM_BITS-1:0] breath_level_reg, breath_level_next;
    logic                breath_up_reg, breath_up_next;
    logic                pwm_tick;

    assign pwm_tick  = (presc_reg == PRE_MAX);
    assign frame_end = pwm_tick && (pwm_cnt_reg == CNT_MAX);

    always_comb begin
        presc_next        = pwm_tick ? '0 : presc_reg + 1'b1;
        pwm_cnt_next      = pwm_tick ? pwm_cnt_reg + 1'b1 : pwm_cnt_reg;
        blink_cnt_next    = blink_cnt_reg;
        blink_phase_next  = blink_phase_reg;
        breath_level_next = breath_level_reg;
        breath_up_next    = breath_up_reg;
        if (frame_end) begin
            if (blink_cnt_reg == BLK_MAX) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
            end
            // The step that lands on an endpoint is the last one in that direction.
            if (breath_up_reg) begin
                breath_level_next = breath_level_reg + 1'b1;
                if (breath_level_reg == BREATH_TOP) breath_up_next = 1'b0;
            end else begin
                breath_level_next = breath_level_reg - 1'b1;
                if (breath_level_reg == BREATH_BOT) breath_up_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            presc_reg        <= '0;
            pwm_cnt_reg      <= '0;
            blink_cnt_reg    <= '0;
            blink_phase_reg  <= 1'b0;
            breath_level_reg <= '0;
            breath_up_reg    <= 1'b1;
        end else begin
            presc_reg        <= presc_next;
            pwm_cnt_reg      <= pwm_cnt_next;
            blink_cnt_reg    <= blink_cnt_next;
            blink_phase_reg  <= blink_phase_next;
            breath_level_reg <= breath_level_next;
            breath_up_reg    <= breath_up_next;
        end
    end

    assign pwm_cnt      = pwm_cnt_reg;
    assign blink_phase  = blink_phase_reg;
    assign breath_level = breath_level_reg;

endmodule

// File: rtl/led_pwm_controller.sv
// Multi-channel LED PWM driver: per-channel shadow/active configuration,
// effective-duty selection and registered LED outputs.
module led_pwm_controller
    import led_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                        clock,
    input  logic                        i_reset,
    input  logic                        i_wr_en,
    input  logic [ch_width(NUM_CH)-1:0] i_wr_ch,
    input  logic [1:0]                  i_wr_mode,
    input  logic [PWM_BITS-1:0]         i_wr_duty,
    output logic [NUM_CH-1:0]           o_led,
    output logic                        o_frame_tick
);
    localparam logic [31:0] NUM_CH_U = NUM_CH;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] breath_level;
    logic                frame_end;
    logic                blink_phase;
    logic                wr_valid;
    logic [NUM_CH-1:0]   led_next;
    logic [NUM_CH-1:0]   led_reg;
    logic                frame_tick_reg;

    pwm_timebase #(
        .PWM_BITS     (PWM_BITS),
        .PRESCALE     (PRESCALE),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timebase (
        .clk          (clock),
        .srst         (i_reset),
        .pwm_cnt      (pwm_cnt),
        .frame_end    (frame_end),
        .blink_phase  (blink_phase),
        .breath_level (breath_level)
    );

    // Out-of-range channel numbers are dropped here so no channel ever matches.
    assign wr_valid = i_wr_en && (32'(i_wr_ch) < NUM_CH_U);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        led_mode_t           shadow_mode_reg, active_mode_reg;
        logic [PWM_BITS-1:0] shadow_duty_reg, active_duty_reg;
        logic [PWM_BITS-1:0] eff_duty;
        logic                wr_hit;

        assign wr_hit = wr_valid && (32'(i_wr_ch) == 32'(gi));

        // Active copy only changes at a frame boundary, so a frame is never torn.
        always_ff @(posedge clock) begin
            if (i_reset) begin
                shadow_mode_reg <= LED_OFF;
                shadow_duty_reg <= '0;
                active_mode_reg <= LED_OFF;
                active_duty_reg <= '0;
            end else begin
                if (wr_hit) begin
                    shadow_mode_reg <= led_mode_t'(i_wr_mode);
                    shadow_duty_reg <= i_wr_duty;
                end
                if (frame_end) begin
                    active_mode_reg <= shadow_mode_reg;
                    active_duty_reg <= shadow_duty_reg;
                end
            end
        end

        always_comb begin
            eff_duty = '0;
            case (active_mode_reg)
                LED_OFF:     eff_duty = '0;
                LED_SOLID:   eff_duty = active_duty_reg;
                LED_BLINK:   eff_duty = blink_phase ? active_duty_reg : '0;
                LED_BREATHE: eff_duty = (breath_level < active_duty_reg) ? breath_level
                                                                         : active_duty_reg;
                default:     eff_duty = '0;
            endcase
        end

        assign led_next[gi] = (pwm_cnt < eff_duty);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            led_reg        <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            led_reg        <= led_next;
            frame_tick_reg <= frame_end;
        end
    end

    assign o_led        = led_reg;
    assign o_frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_led_pwm_controller.sv
// Directed bench: per-frame LED on-cycle counts and frame-tick spacing checked
// against expectations queued by the stimulus.
module tb_led_pwm_controller;
    import led_pkg::*;

    localparam int NUM_CH       = 3;
    localparam int PWM_BITS     = 4;
    localparam int PRESCALE     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = PRESCALE * (2 ** PWM_BITS);
    localparam int PWM_MAX      = (2 ** PWM_BITS) - 1;
    localparam int TRI_PERIOD   = 2 * PWM_MAX;

    typedef logic [NUM_CH-1:0][7:0] counts_t;

    logic                clock = 1'b0;
    logic                i_reset = 1'b1;
    logic                i_wr_en = 1'b0;
    logic [1:0]          i_wr_ch = '0;
    logic [1:0]          i_wr_mode = '0;
    logic [PWM_BITS-1:0] i_wr_duty = '0;
    logic [NUM_CH-1:0]   o_led;
    logic                o_frame_tick;

    int      checks = 0;
    int      errors = 0;
    counts_t exp_q[$];
    counts_t mon_exp;
    int      acc [NUM_CH];
    int      win_len = 0;
    bit      first_win = 1'b1;

    int sh_mode [NUM_CH];
    int sh_duty [NUM_CH];
    int ac_mode [NUM_CH];
    int ac_duty [NUM_CH];
    int fidx = 0;

    always #5 clock = ~clock;

    led_pwm_controller #(
        .NUM_CH       (NUM_CH),
        .PWM_BITS     (PWM_BITS),
        .PRESCALE     (PRESCALE),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_wr_en      (i_wr_en),
        .i_wr_ch      (i_wr_ch),
        .i_wr_mode    (i_wr_mode),
        .i_wr_duty    (i_wr_duty),
        .o_led        (o_led),
        .o_frame_tick (o_frame_tick)
    );

    // Monitor: a window closes on the cycle o_frame_tick is high.
    always @(negedge clock) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
            win_len   = 0;
            first_win = 1'b1;
        end else begin
            win_len++;
            for (int c = 0; c < NUM_CH; c++) acc[c] += int'(o_led[c]);
            if (o_frame_tick) begin
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    checks++;
                    assert (win_len === (first_win ? FRAME_CYC + 1 : FRAME_CYC)) else begin
                        errors++;
                        $error("FAIL frame_len frame=%0d observed %0d expected %0d", fidx,
                               win_len, first_win ? FRAME_CYC + 1 : FRAME_CYC);
                    end
                    for (int c = 0; c < NUM_CH; c++) begin
                        checks++;
                        assert (acc[c] === int'(mon_exp[c])) else begin
                            errors++;
                            $error("FAIL on_cnt_ch%0d observed %0d expected %0d", c, acc[c],
                                   int'(mon_exp[c]));
                        end
                    end
                end
                for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
                win_len   = 0;
                first_win = 1'b0;
            end
        end
    end

    function automatic int tri_level(input int f);
        int t;
        t = f % TRI_PERIOD;
        return (t <= PWM_MAX) ? t : TRI_PERIOD - t;
    endfunction

    function automatic int eff_duty(input int c);
        case (ac_mode[c])
            1:       return ac_duty[c];
            2:       return ((fidx / BLINK_FRAMES) % 2 == 1) ? ac_duty[c] : 0;
            3:       return (tri_level(fidx) < ac_duty[c]) ? tri_level(fidx) : ac_duty[c];
            default: return 0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_expected();
        counts_t e;
        for (int c = 0; c < NUM_CH; c++) e[c] = 8'(eff_duty(c) * PRESCALE);
        exp_q.push_back(e);
    endtask

    task automatic commit();
        for (int c = 0; c < NUM_CH; c++) begin
            ac_mode[c] = sh_mode[c];
            ac_duty[c] = sh_duty[c];
        end
        fidx++;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (o_frame_tick !== 1'b1 && n < 2 * FRAME_CYC);
        checks++;
        assert (o_frame_tick === 1'b1) else begin
            errors++;
            $error("FAIL frame_tick_timeout observed %b expected 1", o_frame_tick);
        end
    endtask

    // Queue the running window, wait for it to close, then model the commit.
    task automatic frame();
        push_expected();
        wait_tick();
        commit();
    endtask

    task automatic write(input int ch, input int mode, input int duty);
        i_wr_en   = 1'b1;
        i_wr_ch   = 2'(ch);
        i_wr_mode = 2'(mode);
        i_wr_duty = PWM_BITS'(duty);
        @(posedge clock);
        #1;
        i_wr_en = 1'b0;
        if (ch < NUM_CH) begin
            sh_mode[ch] = mode;
            sh_duty[ch] = duty;
        end
    endtask

    // Called on the first cycle of a frame; the write lands on the frame_end edge.
    task automatic late_write(input int ch, input int mode, input int duty);
        push_expected();
        idle(FRAME_CYC - 1);
        i_wr_en   = 1'b1;
        i_wr_ch   = 2'(ch);
        i_wr_mode = 2'(mode);
        i_wr_duty = PWM_BITS'(duty);
        @(posedge clock);
        #1;
        i_wr_en = 1'b0;
        checks++;
        assert (o_frame_tick === 1'b1) else begin
            errors++;
            $error("FAIL late_write_align observed %b expected 1", o_frame_tick);
        end
        commit();
        sh_mode[ch] = mode;
        sh_duty[ch] = duty;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            sh_mode[c] = 0;
            sh_duty[c] = 0;
            ac_mode[c] = 0;
            ac_duty[c] = 0;
        end
        fidx = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        i_reset = 1'b0;
        checks++;
        assert (o_led === 3'b000) else begin
            errors++;
            $error("FAIL reset_led observed %b expected 000", o_led);
        end
        checks++;
        assert (o_frame_tick === 1'b0) else begin
            errors++;
            $error("FAIL reset_tick observed %b expected 0", o_frame_tick);
        end

        // Idle after reset: all dark, tick spacing only.
        frame();
        frame();

        // SOLID with several duties, each written mid-frame.
        idle(7);
        write(0, 1, 4);
        frame();
        frame();
        frame();
        idle(3);
        write(0, 1, 15);
        frame();
        frame();
        write(0, 1, 0);
        frame();
        frame();

        // BLINK on ch1.
        idle(3);
        write(1, 2, 8);
        repeat (7) frame();

        // BREATHE on ch2: full triangle, then clipped at duty 6.
        write(2, 3, 15);
        repeat (32) frame();
        write(2, 3, 6);
        repeat (13) frame();

        // Ignored out-of-range channel, frame_end-coincident write, last write wins.
        write(0, 1, 9);
        frame();
        frame();
        idle(2);
        write(3, 1, 15);
        frame();
        frame();
        late_write(0, 1, 2);
        frame();
        frame();
        idle(2);
        write(0, 1, 3);
        write(0, 1, 5);
        frame();
        frame();

        // Reset mid-frame with every channel lit.
        write(0, 1, 15);
        write(1, 1, 15);
        write(2, 1, 15);
        frame();
        frame();
        idle(9);
        checks++;
        assert (o_led === 3'b111) else begin
            errors++;
            $error("FAIL pre_reset_led observed %b expected 111", o_led);
        end
        i_reset = 1'b1;
        @(posedge clock);
        #1;
        exp_q.delete();
        model_reset();
        checks++;
        assert (o_led === 3'b000) else begin
            errors++;
            $error("FAIL mid_reset_led observed %b expected 000", o_led);
        end
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        frame();
        frame();
        frame();

        idle(3);
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL queue_drain observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
